alarm_yonetici: RTL

- Downstream stage of the moving-average temperature alarm.
- Consumes alarm_cal and ortalama_sicaklik, confirms the alarm over consecutive samples, and drives a pulsed siren.
- Supports operator acknowledge (silence) and auto-clear.
- Keeps a saturating alarm-event count and the peak average seen during each alarm episode.

---
 rtl/alarm_yonetici.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alarm_yonetici.sv
// Alarm manager: confirms the raw alarm flag over consecutive samples, drives a
// pulsed siren with operator silence and auto-clear, and tracks event count and episode peak.
module alarm_yonetici #(
   parameter int C                 = 0,
   parameter int ONAY_SAYISI       = 3,
   parameter int TEMIZ_SAYISI      = 4,
   parameter int BIP_YARIM_PERIYOT = 2,
   localparam int W                = 2*C+7
) (
   input  logic         saat,
   input  logic         reset,
   input  logic         alarm_cal,
   input  logic [W-1:0] ortalama_sicaklik,
   input  logic         onay,
   output logic         siren,
   output logic         alarm_aktif,
   output logic [7:0]   olay_sayisi,
   output logic [W-1:0] tepe_sicaklik
);

   localparam logic [3:0] ONAY_HEDEF  = 4'(ONAY_SAYISI);
   localparam logic [3:0] TEMIZ_HEDEF = 4'(TEMIZ_SAYISI);
   localparam logic [3:0] BIP_HEDEF   = 4'(BIP_YARIM_PERIYOT);

   typedef enum logic [1:0] {
      BEKLE      = 2'd0,
      DOGRULA    = 2'd1,
      CALIYOR    = 2'd2,
      SUSTURULDU = 2'd3
   } durum_t;

   durum_t       durum_q, durum_d;
   logic [3:0]   onay_say_q, onay_say_d;
   logic [3:0]   temiz_q, temiz_d;
   logic [3:0]   faz_q, faz_d;
   logic         siren_q, siren_d;
   logic         aktif_q, aktif_d;
   logic [7:0]   olay_q, olay_d;
   logic [W-1:0] tepe_q, tepe_d;

   logic [3:0]   temiz_art;
   logic [W-1:0] tepe_max;

   always_ff @(posedge saat or negedge reset) begin
      if (!reset) begin
         durum_q    <= BEKLE;
         onay_say_q <= '0;
         temiz_q    <= '0;
         faz_q      <= '0;
         siren_q    <= 1'b0;
         aktif_q    <= 1'b0;
         olay_q     <= '0;
         tepe_q     <= '0;
      end else begin
         durum_q    <= durum_d;
         onay_say_q <= onay_say_d;
         temiz_q    <= temiz_d;
         faz_q      <= faz_d;
         siren_q    <= siren_d;
         aktif_q    <= aktif_d;
         olay_q     <= olay_d;
         tepe_q     <= tepe_d;
      end
   end

   // Clear run restarts on any alarm sample; the peak is tracked while an alarm is confirmed.
   assign temiz_art = alarm_cal ? 4'd0 : temiz_q + 4'd1;
   assign tepe_max  = (ortalama_sicaklik > tepe_q) ? ortalama_sicaklik : tepe_q;

   always_comb begin
      durum_d    = durum_q;
      onay_say_d = onay_say_q;
      temiz_d    = temiz_q;
      faz_d      = faz_q;
      siren_d    = siren_q;
      aktif_d    = aktif_q;
      olay_d     = olay_q;
      tepe_d     = tepe_q;

      case (durum_q)
         BEKLE: begin
            if (alarm_cal) begin
               durum_d    = DOGRULA;
               onay_say_d = 4'd1;
            end
         end

         DOGRULA: begin
            if (!alarm_cal) begin
               durum_d    = BEKLE;
               onay_say_d = 4'd0;
            end else if (onay_say_q + 4'd1 == ONAY_HEDEF) begin
               durum_d    = CALIYOR;
               onay_say_d = 4'd0;
               siren_d    = 1'b1;
               aktif_d    = 1'b1;
               olay_d     = (olay_q == 8'hFF) ? olay_q : olay_q + 8'd1;
               tepe_d     = ortalama_sicaklik;
               faz_d      = 4'd1;
               temiz_d    = 4'd0;
            end else begin
               onay_say_d = onay_say_q + 4'd1;
            end
         end

         CALIYOR: begin
            tepe_d  = tepe_max;
            temiz_d = temiz_art;
            // Auto-clear outranks acknowledge when both land on the same edge.
            if (temiz_art == TEMIZ_HEDEF) begin
               durum_d = BEKLE;
               temiz_d = 4'd0;
               siren_d = 1'b0;
               aktif_d = 1'b0;
            end else if (onay) begin
               durum_d = SUSTURULDU;
               siren_d = 1'b0;
            end else if (faz_q == BIP_HEDEF) begin
               siren_d = ~siren_q;
               faz_d   = 4'd1;
            end else begin
               faz_d   = faz_q + 4'd1;
            end
         end

         SUSTURULDU: begin
            tepe_d  = tepe_max;
            temiz_d = temiz_art;
            if (temiz_art == TEMIZ_HEDEF) begin
               durum_d = BEKLE;
               temiz_d = 4'd0;
               aktif_d = 1'b0;
            end
         end

         default: begin
            durum_d = BEKLE;
         end
      endcase
   end

   assign siren         = siren_q;
   assign alarm_aktif   = aktif_q;
   assign olay_sayisi   = olay_q;
   assign tepe_sicaklik = tepe_q;

endmodule
